three_way_bus_router: RTL
=========================

// Module: three_way_bus_router
// PURPOSE
//  Routes one load/store request from the core data port to one of three targets
//  (data RAM, MMIO, timer). Returns the selected target's response to the core.
//  At most one transaction is outstanding. Unmapped and timed-out accesses return
//  an error response.
// PARAMETERS
//  ADDR_WIDTH  32            address width
//  DATA_WIDTH  32            data width; multiple of 8
//  BASE0/MASK0 32'h0000_0000/32'hFFFF_0000  region 0 hit when (addr & MASK0)==BASE0
//  BASE1/MASK1 32'h1000_0000/32'hFFFF_F000  region 1
//  BASE2/MASK2 32'h2000_0000/32'hFFFF_F000  region 2
//  TIMEOUT     16            cycles allowed in ISSUE+WAIT; 0 disables the timeout
// PORTS
//  clk          in   1            clock; all logic on rising edge
//  rst          in   1            synchronous, active-high reset
//  req_valid    in   1            core request valid
//  req_ready    out  1            router can accept a request
//  req_addr     in   ADDR_WIDTH   request address
//  req_wdata    in   DATA_WIDTH   write data
//  req_we       in   1            1=write, 0=read
//  req_be       in   DATA_WIDTH/8 byte enables
//  rsp_valid    out  1            one-cycle response strobe to core
//  rsp_rdata    out  DATA_WIDTH   read data (0 on error)
//  rsp_err      out  1            unmapped address or timeout
//  t_req_valid  out  3            per-target request valid; one-hot or zero
//  t_req_ready  in   3            per-target request ready
//  t_addr       out  ADDR_WIDTH   latched address, broadcast to all targets
//  t_wdata      out  DATA_WIDTH   latched write data, broadcast
//  t_we         out  1            latched write enable, broadcast
//  t_be         out  DATA_WIDTH/8 latched byte enables, broadcast
//  t_rsp_valid  in   3            per-target response valid
//  t_rsp_rdata  in   3*DATA_WIDTH per-target read data; target i at [i*DW +: DW]
// BEHAVIOUR
//  Reset: state=IDLE, counter=0.
//   - All registered outputs are 0: t_req_valid, rsp_valid, rsp_rdata, rsp_err, t_addr, t_wdata, t_we, t_be.
//   - req_ready = (state==IDLE) & ~rst.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE:
//   - req_ready=1.
//   - On req_valid, latch addr, wdata, we and be, and decode the address.
//   - Decode priority on overlapping regions: region 0 > 1 > 2.
//   - Hit region i: sel=i, go to ISSUE.
//   - No hit: go to RESP with err=1 and rdata=0. No target is driven.
//  ISSUE:
//   - t_req_valid[sel]=1. t_addr, t_wdata, t_we and t_be are held stable.
//   - On t_req_ready[sel], drop t_req_valid and go to WAIT.
//   - If t_rsp_valid[sel] arrives in the same cycle as t_req_ready[sel], capture it and go directly to RESP.
//  WAIT:
//   - On t_rsp_valid[sel], capture the rdata slice and go to RESP with err=0.
//  RESP:
//   - rsp_valid=1 for exactly one cycle, then go to IDLE.
//   - rsp_rdata and rsp_err hold their values until the next response.
//  req_ready is 0 in ISSUE, WAIT and RESP; there are no back-to-back accepts.
//  Timeout (TIMEOUT>0):
//   - The counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
//   - If counter==TIMEOUT-1 with no completion, go to RESP next cycle with err=1 and rdata=0.
//   - t_req_valid drops on that edge.
//  Ignored responses:
//   - t_rsp_valid from non-selected targets.
//   - Any t_rsp_valid in IDLE or RESP. These are not buffered.
//  Latency, accept at cycle N:
//   - Unmapped: rsp_valid at N+1.
//   - Target ready at N+1 and rsp at N+2: rsp_valid at N+3.
//   - Timeout: rsp_valid at N+1+TIMEOUT.
//  rst mid-transaction:
//   - Abandons the transaction; no rsp_valid is emitted.
//   - t_req_valid is 0 the cycle after rst.
//   - A late target response is ignored.
// TESTING
//  1. Read 0x0000_0040 at N; t_req_ready[0]=1; t_rsp rdata 0xCAFEF00D at N+2
//     -> t_req_valid=3'b001 at N+1; rsp_valid at N+3 with rdata 0xCAFEF00D, err=0.
//  2. Write 0x1000_0004, wdata 0x1234_5678, be=4'b0011; t_req_ready[1] low for 5 cycles
//     -> t_req_valid[1] and t_addr/t_wdata/t_be stable for 5 cycles; req_ready=0; completes with err=0.
//  3. Read 0x3000_0000 (unmapped) -> t_req_valid stays 0; rsp_valid at N+1 with err=1, rdata=0.
//  4. Read 0x2000_0010 with TIMEOUT=16; target 2 never responds
//     -> rsp_valid at N+17 with err=1; t_req_valid=0 from then.
//  5. t_rsp_valid[2] pulsed during a region-0 transaction and while IDLE -> ignored; the region-0 rdata is returned.
//  6. rst high for 1 cycle in WAIT -> t_req_valid=0, state IDLE, no rsp_valid;
//     the late t_rsp_valid is ignored; the next request completes normally.

Source files
------------

// File: rtl/three_way_bus_router_if.sv
// Bus bundle for three_way_bus_router.
// Carries the core request/response channel and the three-target request/response
// channel.
//
// Handshake rules:
//   - A core request is taken on a rising edge where req_valid & req_ready.
//   - A target request is taken on a rising edge where t_req_valid[i] & t_req_ready[i].
//   - rsp_valid and t_rsp_valid[i] are single-cycle strobes with no back-pressure.
//
// Modports:
//   slave  - the router itself: receives core requests and drives the targets.
//   master - the environment: drives core requests and models the targets.
interface three_way_bus_router_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      req_we;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic [2:0]                t_req_valid;
  logic [2:0]                t_req_ready;
  logic [ADDR_WIDTH-1:0]     t_addr;
  logic [DATA_WIDTH-1:0]     t_wdata;
  logic                      t_we;
  logic [DATA_WIDTH/8-1:0]   t_be;
  logic [2:0]                t_rsp_valid;
  logic [3*DATA_WIDTH-1:0]   t_rsp_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output t_req_valid, t_addr, t_wdata, t_we, t_be,
    input  t_req_ready, t_rsp_valid, t_rsp_rdata
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  t_req_valid, t_addr, t_wdata, t_we, t_be,
    output t_req_ready, t_rsp_valid, t_rsp_rdata
  );
endinterface

// File: rtl/three_way_bus_router.sv
// Routes a single outstanding load/store from the core data port to one of three
// targets (data RAM, MMIO, timer) by address decode, and returns that target's
// response. Unmapped and timed-out accesses return err=1 with rdata=0.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - core + target bus bundle (slave modport)
//   state_dbg - current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module three_way_bus_router #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE0 = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] MASK0 = 32'hFFFF_0000,
  parameter logic [ADDR_WIDTH-1:0] BASE1 = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] MASK1 = 32'hFFFF_F000,
  parameter logic [ADDR_WIDTH-1:0] BASE2 = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] MASK2 = 32'hFFFF_F000,
  parameter int                    TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  three_way_bus_router_if.slave  bus,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]            state;
  logic [1:0]            sel;
  logic [CNT_W-1:0]      cnt;
  logic                  hit0, hit1, hit2;
  logic                  sel_ready;
  logic                  sel_rsp;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timed_out;

  assign state_dbg = state;
  assign bus.req_ready = (state == IDLE) & ~rst;

  assign hit0 = (bus.req_addr & MASK0) == BASE0;
  assign hit1 = (bus.req_addr & MASK1) == BASE1;
  assign hit2 = (bus.req_addr & MASK2) == BASE2;

  // Only the selected target's handshake and data are looked at; everything
  // arriving from the other two targets is dropped.
  always_comb begin
    sel_ready = 1'b0;
    sel_rsp   = 1'b0;
    sel_rdata = '0;
    case (sel)
      2'd0: begin
        sel_ready = bus.t_req_ready[0];
        sel_rsp   = bus.t_rsp_valid[0];
        sel_rdata = bus.t_rsp_rdata[0*DATA_WIDTH +: DATA_WIDTH];
      end
      2'd1: begin
        sel_ready = bus.t_req_ready[1];
        sel_rsp   = bus.t_rsp_valid[1];
        sel_rdata = bus.t_rsp_rdata[1*DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_ready = bus.t_req_ready[2];
        sel_rsp   = bus.t_rsp_valid[2];
        sel_rdata = bus.t_rsp_rdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  // Last cycle allowed in ISSUE+WAIT; TIMEOUT=0 never expires.
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sel             <= 2'd0;
      cnt             <= '0;
      bus.t_req_valid <= 3'b000;
      bus.t_addr      <= '0;
      bus.t_wdata     <= '0;
      bus.t_we        <= 1'b0;
      bus.t_be        <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.t_addr  <= bus.req_addr;
            bus.t_wdata <= bus.req_wdata;
            bus.t_we    <= bus.req_we;
            bus.t_be    <= bus.req_be;
            cnt         <= '0;
            // Overlapping regions resolve to the lowest index.
            if (hit0) begin
              sel             <= 2'd0;
              bus.t_req_valid <= 3'b001;
              state           <= ISSUE;
            end else if (hit1) begin
              sel             <= 2'd1;
              bus.t_req_valid <= 3'b010;
              state           <= ISSUE;
            end else if (hit2) begin
              sel             <= 2'd2;
              bus.t_req_valid <= 3'b100;
              state           <= ISSUE;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= RESP;
            end
          end
        end
        ISSUE: begin
          if (sel_ready && sel_rsp) begin
            // Target accepted and answered in the same cycle.
            bus.t_req_valid <= 3'b000;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= sel_rdata;
            state           <= RESP;
          end else if (timed_out) begin
            bus.t_req_valid <= 3'b000;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= 1'b1;
            bus.rsp_rdata   <= '0;
            state           <= RESP;
          end else if (sel_ready) begin
            bus.t_req_valid <= 3'b000;
            cnt             <= cnt + CNT_W'(1);
            state           <= WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (sel_rsp) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= sel_rdata;
            state         <= RESP;
          end else if (timed_out) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
